wb_image_loader: RTL and testbench

- Parametrised loader that moves an HPS ioctl download (ROM/OS image) into Wishbone-attached SDRAM.
- Before accepting data it optionally erases a region with a fill pattern.
- Packs 8- or 16-bit ioctl beats into byte-masked 32-bit Wishbone writes.
- Sits between hps_io and the SDRAM arbiter mux; its `active` output steers that mux, and `hold_reset` holds the core in reset.

---
 rtl/archie_ld_pkg.sv | 28 ++
 rtl/wb_write_port.sv | 55 +++++
 rtl/wb_image_loader.sv | 207 ++++++++++++++++++++
 tb/tb_wb_image_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/archie_ld_pkg.sv
// Shared types and helpers for the Wishbone image loader: FSM state encoding,
// byte-lane select and write-data replication for 8/16-bit download beats.
package archie_ld_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StErase,
    StLoad,
    StFinish
  } ld_state_e;

  // Byte lanes of the 32-bit word touched by one download beat.
  function automatic logic [3:0] lane_sel(input logic [1:0] addr_lo, input int unsigned io_dw);
    if (io_dw == 16) begin
      return addr_lo[1] ? 4'b1100 : 4'b0011;
    end
    return 4'b0001 << addr_lo;
  endfunction

  // Beat replicated across the word so any selected lane carries the data.
  function automatic logic [31:0] rep_data(input logic [15:0] dout, input int unsigned io_dw);
    if (io_dw == 16) begin
      return {dout, dout};
    end
    return {4{dout[7:0]}};
  endfunction

endpackage

// File: rtl/wb_write_port.sv
// Single-outstanding masked Wishbone write master: latches one request and
// holds cyc/stb/adr/sel/dat stable until the slave acknowledges.
module wb_write_port #(
  parameter int unsigned AW = 24
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [AW-1:0] i_adr,
  input  logic [3:0]    i_sel,
  input  logic [31:0]   i_dat,
  input  logic          i_ack,
  output logic          o_cyc,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_adr,
  output logic [3:0]    o_sel,
  output logic [31:0]   o_dat,
  output logic          o_busy,
  output logic          o_ack
);

  logic          r_stb;
  logic [AW-1:0] r_adr;
  logic [3:0]    r_sel;
  logic [31:0]   r_dat;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stb <= 1'b0;
      r_adr <= '0;
      r_sel <= '0;
      r_dat <= '0;
    end else if (r_stb) begin
      if (i_ack) begin
        r_stb <= 1'b0;
      end
    end else if (i_start) begin
      r_stb <= 1'b1;
      r_adr <= i_adr;
      r_sel <= i_sel;
      r_dat <= i_dat;
    end
  end

  assign o_cyc  = r_stb;
  assign o_stb  = r_stb;
  assign o_we   = r_stb;
  assign o_adr  = r_adr;
  assign o_sel  = r_sel;
  assign o_dat  = r_dat;
  assign o_busy = r_stb;
  assign o_ack  = r_stb & i_ack;

endmodule

// File: rtl/wb_image_loader.sv
// Moves an hps_io ioctl download into Wishbone SDRAM, optionally erasing the region first.
// Define LOADER_SUM_EN to add the `sum` output (running sum of accepted beats).
module wb_image_loader
  import archie_ld_pkg::*;
#(
  parameter logic [7:0]  DL_INDEX    = 8'd1,
  parameter int unsigned IO_DW       = 16,
  parameter int unsigned WB_AW       = 24,
  parameter int unsigned BASE_WADDR  = 'h100000,
  parameter int unsigned ERASE_WORDS = 'h100000,
  parameter logic [31:0] FILL        = 32'h0
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ioctl_download,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [IO_DW-1:0] ioctl_dout,
  output logic             ioctl_wait,
  output logic             active,
  output logic             hold_reset,
  output logic             done,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  output logic [3:0]       wb_sel,
  output logic [WB_AW+1:2] wb_adr,
  output logic [31:0]      wb_dat_o,
  input  logic             wb_ack,
  output logic             ovf
`ifdef LOADER_SUM_EN
  ,
  output logic [31:0]      sum
`endif
);

  localparam int unsigned AddrW = (WB_AW + 2 > 25) ? WB_AW + 2 : 25;

  ld_state_e  r_state;
  logic       r_sel_prev;
  logic       r_dl_gone;
  logic       r_active;
  logic       r_hold;
  logic       r_done;
  logic       r_wait;
  logic       r_ovf;
  logic [31:0] r_idx;
`ifdef LOADER_SUM_EN
  logic [31:0] r_sum;
`endif

  logic             w_sel_dl;
  logic             w_sel_rise;
  logic [AddrW-1:0] w_addr_ext;
  logic [WB_AW-1:0] w_offset;
  logic [15:0]      w_dout16;
  logic             w_oor;
  logic             w_busy;
  logic             w_ack;
  logic             w_accept;
  logic             w_drop;
  logic             w_erase_req;
  logic             w_start;
  logic [WB_AW-1:0] w_req_adr;
  logic [3:0]       w_req_sel;
  logic [31:0]      w_req_dat;

  assign w_sel_dl   = ioctl_download && (ioctl_index == DL_INDEX);
  assign w_sel_rise = w_sel_dl && !r_sel_prev;
  assign w_addr_ext = AddrW'(ioctl_addr);
  assign w_offset   = w_addr_ext[WB_AW+1:2];
  assign w_dout16   = 16'(ioctl_dout);
  // With erase disabled there is no region bound, so every offset is accepted.
  assign w_oor      = (ERASE_WORDS != 0) && (32'(w_offset) >= ERASE_WORDS);

  assign w_accept    = (r_state == StLoad) && ioctl_wr && w_sel_dl && !w_busy && !w_oor;
  assign w_drop      = (r_state == StLoad) && ioctl_wr && w_sel_dl && (w_busy || w_oor);
  assign w_erase_req = (r_state == StErase) && !w_busy && (r_idx < ERASE_WORDS);
  assign w_start     = w_accept || w_erase_req;

  always_comb begin
    w_req_adr = WB_AW'(BASE_WADDR + 32'(w_offset));
    w_req_sel = lane_sel(w_addr_ext[1:0], IO_DW);
    w_req_dat = rep_data(w_dout16, IO_DW);
    if (r_state == StErase) begin
      w_req_adr = WB_AW'(BASE_WADDR + r_idx);
      w_req_sel = 4'b1111;
      w_req_dat = FILL;
    end
  end

  wb_write_port #(
    .AW (WB_AW)
  ) u_port (
    .i_clk   (clk_sys),
    .i_rst_n (reset_n),
    .i_start (w_start),
    .i_adr   (w_req_adr),
    .i_sel   (w_req_sel),
    .i_dat   (w_req_dat),
    .i_ack   (wb_ack),
    .o_cyc   (wb_cyc),
    .o_stb   (wb_stb),
    .o_we    (wb_we),
    .o_adr   (wb_adr),
    .o_sel   (wb_sel),
    .o_dat   (wb_dat_o),
    .o_busy  (w_busy),
    .o_ack   (w_ack)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_sel_prev <= 1'b0;
      r_dl_gone  <= 1'b0;
      r_active   <= 1'b0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_wait     <= 1'b0;
      r_ovf      <= 1'b0;
      r_idx      <= '0;
`ifdef LOADER_SUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_sel_prev <= w_sel_dl;
      r_done     <= 1'b0;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (w_sel_rise) begin
            r_active  <= 1'b1;
            r_hold    <= 1'b1;
            r_idx     <= '0;
            r_dl_gone <= 1'b0;
`ifdef LOADER_SUM_EN
            r_sum     <= '0;
`endif
            if (ERASE_WORDS != 0) begin
              r_state <= StErase;
              r_wait  <= 1'b1;
            end else begin
              r_state <= StLoad;
            end
          end
        end
        StErase: begin
          if (!w_sel_dl) begin
            r_dl_gone <= 1'b1;
          end
          if (w_erase_req) begin
            r_idx <= r_idx + 32'd1;
          end
          if (w_ack && (r_idx == ERASE_WORDS)) begin
            r_wait <= 1'b0;
            if (r_dl_gone || !w_sel_dl) begin
              r_state  <= StFinish;
              r_done   <= 1'b1;
              r_active <= 1'b0;
              r_hold   <= 1'b0;
            end else begin
              r_state <= StLoad;
            end
          end
        end
        StLoad: begin
          if (w_accept) begin
            r_wait <= 1'b1;
`ifdef LOADER_SUM_EN
            r_sum  <= r_sum + 32'(w_dout16);
`endif
          end else if (w_ack) begin
            r_wait <= 1'b0;
          end
          // Download ended: let any pending write retire before finishing.
          if (!w_sel_dl && (!w_busy || w_ack)) begin
            r_state  <= StFinish;
            r_done   <= 1'b1;
            r_active <= 1'b0;
            r_hold   <= 1'b0;
            r_wait   <= 1'b0;
          end
        end
        StFinish: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign ioctl_wait = r_wait;
  assign active     = r_active;
  assign hold_reset = r_hold;
  assign done       = r_done;
  assign ovf        = r_ovf;
`ifdef LOADER_SUM_EN
  assign sum        = r_sum;
`endif

endmodule

// File: tb/tb_wb_image_loader.sv
// Scoreboard bench for wb_image_loader: three instances (erase, 16-bit load, 8-bit load)
// share the ioctl bus and are told apart by ioctl_index.
module tb_wb_image_loader;

  localparam int unsigned BASE    = 'h100000;
  localparam int          ACK_DLY = 2;
  localparam int          LIM     = 200;

  typedef struct packed {
    logic [1:0]  inst;
    logic [23:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;

  logic [2:0]  iwait, active, hrst, done, cyc, stb, we, ovf;
  logic [2:0]  ack = 3'b000;
  logic [2:0]  ack_hold = 3'b000;
  logic [3:0]  sel [3];
  logic [23:0] adr [3];
  logic [31:0] dat [3];
`ifdef LOADER_SUM_EN
  logic [31:0] sum [3];
`endif

  int  cnt [3];
  int  hs [3];
  int  n_vec = 0;
  int  n_err = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  wb_image_loader #(
    .DL_INDEX (8'd1), .IO_DW (16), .WB_AW (24), .BASE_WADDR (BASE),
    .ERASE_WORDS (4), .FILL (32'hDEADBEEF)
  ) u_erase (
    .clk_sys (clk), .reset_n (reset_n), .ioctl_download (ioctl_download),
    .ioctl_index (ioctl_index), .ioctl_wr (ioctl_wr), .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout), .ioctl_wait (iwait[0]), .active (active[0]),
    .hold_reset (hrst[0]), .done (done[0]), .wb_cyc (cyc[0]), .wb_stb (stb[0]),
    .wb_we (we[0]), .wb_sel (sel[0]), .wb_adr (adr[0]), .wb_dat_o (dat[0]),
    .wb_ack (ack[0]), .ovf (ovf[0])
`ifdef LOADER_SUM_EN
    , .sum (sum[0])
`endif
  );

  wb_image_loader #(
    .DL_INDEX (8'd2), .IO_DW (16), .WB_AW (24), .BASE_WADDR (BASE),
    .ERASE_WORDS (0), .FILL (32'h0)
  ) u_load16 (
    .clk_sys (clk), .reset_n (reset_n), .ioctl_download (ioctl_download),
    .ioctl_index (ioctl_index), .ioctl_wr (ioctl_wr), .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout), .ioctl_wait (iwait[1]), .active (active[1]),
    .hold_reset (hrst[1]), .done (done[1]), .wb_cyc (cyc[1]), .wb_stb (stb[1]),
    .wb_we (we[1]), .wb_sel (sel[1]), .wb_adr (adr[1]), .wb_dat_o (dat[1]),
    .wb_ack (ack[1]), .ovf (ovf[1])
`ifdef LOADER_SUM_EN
    , .sum (sum[1])
`endif
  );

  wb_image_loader #(
    .DL_INDEX (8'd3), .IO_DW (8), .WB_AW (24), .BASE_WADDR (BASE),
    .ERASE_WORDS (0), .FILL (32'h0)
  ) u_load8 (
    .clk_sys (clk), .reset_n (reset_n), .ioctl_download (ioctl_download),
    .ioctl_index (ioctl_index), .ioctl_wr (ioctl_wr), .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout[7:0]), .ioctl_wait (iwait[2]), .active (active[2]),
    .hold_reset (hrst[2]), .done (done[2]), .wb_cyc (cyc[2]), .wb_stb (stb[2]),
    .wb_we (we[2]), .wb_sel (sel[2]), .wb_adr (adr[2]), .wb_dat_o (dat[2]),
    .wb_ack (ack[2]), .ovf (ovf[2])
`ifdef LOADER_SUM_EN
    , .sum (sum[2])
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Slave model (ack after ACK_DLY stalled cycles) plus scoreboard monitor.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack[i]) begin
        ack[i] = 1'b0;
      end else if (!stb[i]) begin
        cnt[i] = 0;
      end else if (!ack_hold[i]) begin
        if (cnt[i] >= ACK_DLY) ack[i] = 1'b1;
        else cnt[i]++;
      end
      if (stb[i] && ack[i]) begin
        wr_t got;
        got = '{inst: 2'(i), adr: adr[i], sel: sel[i], dat: dat[i]};
        hs[i]++;
        cnt[i] = 0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL wb_write_unexpected: got inst %0d adr %h sel %h dat %h, required none",
                   i, adr[i], sel[i], dat[i]);
        end else begin
          chk("wb_write", 64'(got), 64'(exp_q.pop_front()));
          chk("wb_we_cyc", {62'd0, we[i], cyc[i]}, 64'd3);
        end
      end
    end
  end

  task automatic push(input int i, input logic [23:0] a, input logic [3:0] s,
                      input logic [31:0] d);
    exp_q.push_back('{inst: 2'(i), adr: a, sel: s, dat: d});
  endtask

  task automatic dl_start(input logic [7:0] idx);
    @(posedge clk); #1;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
  endtask

  task automatic dl_stop();
    @(posedge clk); #1;
    ioctl_download = 1'b0;
  endtask

  task automatic pulse_wr(input logic [24:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(posedge clk); #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic beat(input int i, input logic [24:0] a, input logic [15:0] d);
    int t = 0;
    @(negedge clk);
    while (iwait[i] && t < LIM) begin
      @(negedge clk);
      t++;
    end
    chk("beat_wait_timeout", 64'(t >= LIM), 64'd0);
    pulse_wr(a, d);
  endtask

  task automatic wait_hs(input int i, input int prev);
    int t = 0;
    while (hs[i] == prev && t < LIM) begin
      @(posedge clk);
      t++;
    end
    chk("handshake_timeout", 64'(t >= LIM), 64'd0);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < LIM) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", 64'(t >= LIM), 64'd0);
  endtask

  task automatic wait_done(input int i);
    int t = 0;
    @(negedge clk);
    while (!done[i] && t < LIM) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", 64'(t >= LIM), 64'd0);
    @(negedge clk);
    chk("done_after", {61'd0, done[i], active[i], hrst[i]}, 64'd0);
  endtask

  initial begin
    int prev;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_ctrl", {56'd0, cyc[i], stb[i], we[i], active[i], hrst[i], done[i], iwait[i],
          ovf[i]}, 64'd0);
      chk("reset_bus", {adr[i], sel[i], dat[i]}, 64'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Erase four words, one idle cycle between requests.
    for (int k = 0; k < 4; k++) push(0, 24'(BASE + k), 4'hF, 32'hDEADBEEF);
    prev = hs[0];
    dl_start(8'd1);
    @(posedge clk);
    @(negedge clk);
    chk("erase_start", {61'd0, active[0], hrst[0], iwait[0]}, 64'd7);
    for (int k = 0; k < 4; k++) begin
      wait_hs(0, prev);
      prev = hs[0];
      @(negedge clk);
      chk("erase_gap_stb", 64'(stb[0]), 64'd0);
      chk("erase_wait", 64'(iwait[0]), 64'(k < 3));
      if (k < 3) begin
        @(negedge clk);
        chk("erase_next_stb", 64'(stb[0]), 64'd1);
      end
    end

    // Stalled write: second strobe is dropped and flags ovf.
    ack_hold[0] = 1'b1;
    push(0, 24'(BASE), 4'b0011, 32'h11111111);
    beat(0, 25'd0, 16'h1111);
    repeat (3) @(negedge clk);
    chk("stall_state", {61'd0, stb[0], iwait[0], ovf[0]}, 64'd6);
    pulse_wr(25'd2, 16'h2222);
    @(negedge clk);
    chk("stall_ovf", 64'(ovf[0]), 64'd1);
    ack_hold[0] = 1'b0;
    drain();
    repeat (6) @(posedge clk);
    dl_stop();
    wait_done(0);

    // Reset mid-erase with stb high, then a fresh erase from BASE+0.
    dl_start(8'd1);
    begin
      int t = 0;
      @(negedge clk);
      while (!stb[0] && t < LIM) begin
        @(negedge clk);
        t++;
      end
      chk("erase_stb_timeout", 64'(t >= LIM), 64'd0);
    end
    @(posedge clk); #1;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_mid_erase", {59'd0, stb[0], cyc[0], active[0], iwait[0], ovf[0]}, 64'd0);
    for (int k = 0; k < 4; k++) push(0, 24'(BASE + k), 4'hF, 32'hDEADBEEF);
    dl_start(8'd1);
    drain();
    // Beyond the erased region: dropped, no bus cycle.
    beat(0, 25'd64, 16'h7777);
    @(negedge clk);
    chk("oor_ovf", {62'd0, ovf[0], stb[0]}, 64'd2);
    repeat (6) @(posedge clk);
    dl_stop();
    wait_done(0);

    // 16-bit loads, download drops while the last write is pending.
    push(1, 24'(BASE), 4'b0011, 32'h12341234);
    push(1, 24'(BASE), 4'b1100, 32'h56785678);
    dl_start(8'd2);
    @(posedge clk);
    @(negedge clk);
    chk("load16_start", {61'd0, active[1], hrst[1], iwait[1]}, 64'd6);
    beat(1, 25'd0, 16'h1234);
    @(negedge clk);
    chk("load16_pending", {62'd0, stb[1], iwait[1]}, 64'd3);
    beat(1, 25'd2, 16'h5678);
    prev = hs[1];
    dl_stop();
    wait_hs(1, prev);
    @(negedge clk);
    chk("load16_done_pulse", {62'd0, done[1], active[1]}, 64'd2);
    @(negedge clk);
    chk("load16_done_end", {61'd0, done[1], active[1], hrst[1]}, 64'd0);
`ifdef LOADER_SUM_EN
    chk("sum_a", 64'(sum[1]), 64'h68AC);
`endif

    push(1, 24'(BASE), 4'b0011, 32'hFFFFFFFF);
    push(1, 24'(BASE), 4'b1100, 32'h00020002);
    dl_start(8'd2);
    beat(1, 25'd0, 16'hFFFF);
    beat(1, 25'd2, 16'h0002);
    drain();
    dl_stop();
    wait_done(1);
`ifdef LOADER_SUM_EN
    chk("sum_b", 64'(sum[1]), 64'h00010001);
`endif

    // 8-bit load: byte 7 lands in lane 3 of word 1.
    push(2, 24'(BASE + 1), 4'b1000, 32'hA5A5A5A5);
    dl_start(8'd3);
    beat(2, 25'd7, 16'h00A5);
    drain();
    dl_stop();
    wait_done(2);

    repeat (4) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("no_ovf_loaders", {62'd0, ovf[2], ovf[1]}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
